// File: rtl/noc_dmem_pkg.sv
// Shared definitions for the two-requester data-memory arbiter.
package noc_dmem_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;

  // Arbiter state: StIdle = no read pending, StRdRet = read data returns this cycle.
  typedef enum logic {
    StIdle  = 1'b0,
    StRdRet = 1'b1
  } arb_state_e;

  // Index of one of the two requesters.
  typedef logic req_idx_t;

endpackage

// File: rtl/noc_dmem_arb2.sv
// Two-way grant logic. Round-robin when NOC_DMEM_ARB_RR_EN is defined,
// otherwise fixed priority with requester 0 highest.
module noc_dmem_arb2
  import noc_dmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

`ifdef NOC_DMEM_ARB_RR_EN
  req_idx_t ptr_q, ptr_d;

  // Grant the pointed-to requester on contention; pointer then flips to the other one.
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (accept) begin
      if (req == 2'b11) begin
        gnt = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: requester 0 wins every contention.
  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      if (req[0]) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

  // Clock and reset are only needed by the pointer in the round-robin build.
  logic unused_clk_reset;
  assign unused_clk_reset = ^{clk, reset};
`endif

endmodule

// File: rtl/noc_dmem_arbiter.sv
// Arbitrates two Avalon-MM requesters onto one single-port data memory with
// fixed 1-cycle read latency. Define NOC_DMEM_ARB_RR_EN for round-robin arbitration.
module noc_dmem_arbiter
  import noc_dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       rd_acc;
  logic       rd_pend;
  arb_state_e state_q, state_d;
  req_idx_t   rd_owner_q, rd_owner_d;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  noc_dmem_arb2 u_arb2 (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .accept (~reset),
    .gnt    (gnt)
  );

  // Memory-side mux; write wins when read and write are both asserted.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (gnt[0]) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
    end else if (gnt[1]) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  assign mem_chipselect = |gnt;
  assign mem_clken      = ~reset;
  assign m0_waitrequest = reset | (req[0] & ~gnt[0]);
  assign m1_waitrequest = reset | (req[1] & ~gnt[1]);

  assign rd_acc = (gnt[0] & m0_read & ~m0_write) | (gnt[1] & m1_read & ~m1_write);

  // Next state: a granted read always produces a return in the following cycle.
  always_comb begin
    state_d    = StIdle;
    rd_owner_d = rd_owner_q;
    if (rd_acc) begin
      state_d    = StRdRet;
      rd_owner_d = gnt[1];
    end
  end

  // State and read-owner registers; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign rd_pend          = (state_q == StRdRet) & ~reset;
  assign m0_readdatavalid = rd_pend & (rd_owner_q == 1'b0);
  assign m1_readdatavalid = rd_pend & (rd_owner_q == 1'b1);
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_noc_dmem_arbiter.sv
// Directed bench for noc_dmem_arbiter with a behavioural synchronous RAM.
module tb_noc_dmem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [3:0]    m0_byteenable, m1_byteenable, mem_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, mem_writedata;
  logic [DW-1:0] m0_readdata, m1_readdata, mem_readdata;
  logic          m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest;
  logic          mem_chipselect, mem_write, mem_clken;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;

  always #5 clk = ~clk;

  noc_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m0_waitrequest   (m0_waitrequest),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_waitrequest   (m1_waitrequest),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // Synchronous RAM with byte enables; read data appears one cycle after the address.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
      ram_q <= ram[mem_address];
    end
  end
  assign mem_readdata = ram_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [3:0] be);
    m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
  endtask

  task automatic drv1(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [3:0] be);
    m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
  endtask

  // Advance to the next cycle window; inputs driven after this settle before the posedge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    ram_q = '0;
    reset = 1'b1;
    drv0(1'b1, 1'b0, 12'h003, 32'h0, 4'hF);
    drv1(1'b0, 1'b1, 12'h004, 32'h1234, 4'hF);

    // Reset cycles with both requesters active.
    next_cycle(); #1;
    chk("rst_wait0", m0_waitrequest, 1'b1);
    chk("rst_wait1", m1_waitrequest, 1'b1);
    chk("rst_cs", mem_chipselect, 1'b0);
    chk("rst_we", mem_write, 1'b0);
    chk("rst_clken", mem_clken, 1'b0);
    chk("rst_rdv0", m0_readdatavalid, 1'b0);
    next_cycle(); #1;
    chk("rst_rdv1", m1_readdatavalid, 1'b0);

    // Single write by m0, accepted in the first cycle after reset.
    reset = 1'b0;
    drv0(1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    drv1(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    #1;
    chk("wr_we", mem_write, 1'b1);
    chk("wr_addr", mem_address, 12'h010);
    chk("wr_data", mem_writedata, 32'hDEADBEEF);
    chk("wr_wait0", m0_waitrequest, 1'b0);
    chk("wr_wait1", m1_waitrequest, 1'b0);
    chk("wr_clken", mem_clken, 1'b1);

    next_cycle();
    drv0(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    drv1(1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
    #1;
    chk("rd1_cs", mem_chipselect, 1'b1);
    chk("rd1_we", mem_write, 1'b0);
    chk("rd1_wait1", m1_waitrequest, 1'b0);
    chk("rd1_rdv_early", m1_readdatavalid, 1'b0);

    next_cycle();
    drv1(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    #1;
    chk("rd1_rdv", m1_readdatavalid, 1'b1);
    chk("rd1_data", m1_readdata, 32'hDEADBEEF);
    chk("rd1_rdv0", m0_readdatavalid, 1'b0);
    chk("rd1_rdata0", m0_readdata, 32'h0);
    chk("idle_cs", mem_chipselect, 1'b0);
    chk("idle_addr", mem_address, 12'h000);
    next_cycle(); #1;
    chk("rd1_rdv_once", m1_readdatavalid, 1'b0);
    chk("rd1_rdata_zero", m1_readdata, 32'h0);

    // Byte lanes.
    drv0(1'b0, 1'b1, 12'h005, 32'h11223344, 4'hF);
    next_cycle();
    drv0(1'b0, 1'b1, 12'h005, 32'hAABBCCDD, 4'h3);
    next_cycle();
    drv0(1'b1, 1'b0, 12'h005, 32'h0, 4'hF);
    next_cycle();
    drv0(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    #1;
    chk("be_rdv0", m0_readdatavalid, 1'b1);
    chk("be_data", m0_readdata, 32'h1122CCDD);

    // Preload addresses 1..3 from m1, then back-to-back reads from m0.
    next_cycle(); drv1(1'b0, 1'b1, 12'h001, 32'h101, 4'hF);
    next_cycle(); drv1(1'b0, 1'b1, 12'h002, 32'h202, 4'hF);
    next_cycle(); drv1(1'b0, 1'b1, 12'h003, 32'h303, 4'hF);
    next_cycle();
    drv1(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    drv0(1'b1, 1'b0, 12'h001, 32'h0, 4'hF);
    next_cycle();
    drv0(1'b1, 1'b0, 12'h002, 32'h0, 4'hF);
    #1;
    chk("b2b_wait0", m0_waitrequest, 1'b0);
    chk("b2b_rdv_a", m0_readdatavalid, 1'b1);
    chk("b2b_data_a", m0_readdata, 32'h101);
    next_cycle();
    drv0(1'b1, 1'b0, 12'h003, 32'h0, 4'hF);
    #1;
    chk("b2b_rdv_b", m0_readdatavalid, 1'b1);
    chk("b2b_data_b", m0_readdata, 32'h202);
    next_cycle();
    drv0(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    #1;
    chk("b2b_rdv_c", m0_readdatavalid, 1'b1);
    chk("b2b_data_c", m0_readdata, 32'h303);
    next_cycle(); #1;
    chk("b2b_rdv_end", m0_readdatavalid, 1'b0);

    // Reset in the return cycle of an m1 read.
    drv1(1'b1, 1'b0, 12'h002, 32'h0, 4'hF);
    #1;
    chk("rr_acc1", m1_waitrequest, 1'b0);
    next_cycle();
    reset = 1'b1;
    drv0(1'b1, 1'b0, 12'h001, 32'h0, 4'hF);
    drv1(1'b1, 1'b0, 12'h003, 32'h0, 4'hF);
    #1;
    chk("mid_rdv1", m1_readdatavalid, 1'b0);
    chk("mid_rdata1", m1_readdata, 32'h0);
    chk("mid_wait0", m0_waitrequest, 1'b1);
    chk("mid_wait1", m1_waitrequest, 1'b1);
    next_cycle();
    reset = 1'b0;
    #1;
    chk("post_rdv1", m1_readdatavalid, 1'b0);
    chk("post_wait0", m0_waitrequest, 1'b0);
    chk("post_wait1", m1_waitrequest, 1'b1);

    // Contention continues with both commands held.
    next_cycle(); #1;
    chk("ct_rdv0", m0_readdatavalid, 1'b1);
    chk("ct_data0", m0_readdata, 32'h101);
`ifdef NOC_DMEM_ARB_RR_EN
    chk("ct_rr_wait0", m0_waitrequest, 1'b1);
    chk("ct_rr_wait1", m1_waitrequest, 1'b0);
    next_cycle(); #1;
    chk("ct_rr_rdv1", m1_readdatavalid, 1'b1);
    chk("ct_rr_data1", m1_readdata, 32'h303);
    chk("ct_rr_wait0b", m0_waitrequest, 1'b0);
    chk("ct_rr_wait1b", m1_waitrequest, 1'b1);
`else
    chk("ct_fp_wait0", m0_waitrequest, 1'b0);
    chk("ct_fp_wait1", m1_waitrequest, 1'b1);
    next_cycle(); #1;
    chk("ct_fp_rdv0b", m0_readdatavalid, 1'b1);
    chk("ct_fp_rdv1b", m1_readdatavalid, 1'b0);
    chk("ct_fp_wait1b", m1_waitrequest, 1'b1);
`endif

    // Illegal read+write: write wins, no read return.
    next_cycle();
    drv0(1'b1, 1'b1, 12'h007, 32'h5, 4'hF);
    drv1(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    #1;
    chk("ill_we", mem_write, 1'b1);
    chk("ill_addr", mem_address, 12'h007);
    chk("ill_wait0", m0_waitrequest, 1'b0);
    next_cycle();
    drv0(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    drv1(1'b1, 1'b0, 12'h007, 32'h0, 4'hF);
    #1;
    chk("ill_no_rdv0", m0_readdatavalid, 1'b0);
    next_cycle();
    drv1(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    #1;
    chk("ill_rdv1", m1_readdatavalid, 1'b1);
    chk("ill_data", m1_readdata, 32'h5);

    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
